// File: rtl/uart_mmio.sv
// Memory-mapped responder for the on-board UART chip: decodes MEM-stage accesses at
// DATA_ADDR/STAT_ADDR, sequences the rdn/wrn strobes over the shared Ram1 low byte, and stalls until done.
module uart_mmio #(
    parameter logic [15:0] DATA_ADDR = 16'hBF00,
    parameter logic [15:0] STAT_ADDR = 16'hBF01,
    parameter int          RD_PULSE  = 2,
    parameter int          WR_PULSE  = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [15:0] DataOut,
    output logic        Hit,
    output logic        Ram1_Off,
    output logic        Stall,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    inout  wire  [7:0]  Uart_data,
    output logic [2:0]  dbg_state_o
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD       = 3'd1;
    localparam logic [2:0] WR_SETUP = 3'd2;
    localparam logic [2:0] WR       = 3'd3;
    localparam logic [2:0] WR_HOLD  = 3'd4;
    localparam logic [2:0] WR_WAIT  = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam int PMAX = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rx_q, rx_d, tx_q, tx_d;
    logic          abort_q, abort_d;
    logic          rdn_q, wrn_q, drive_q;
    logic [1:0]    dr_sync_q, tbre_sync_q, tsre_sync_q;
    logic          dr_s, tbre_s, tsre_s;
    logic          is_data, is_stat, data_hit, live;

    assign dr_s   = dr_sync_q[1];
    assign tbre_s = tbre_sync_q[1];
    assign tsre_s = tsre_sync_q[1];

    assign is_data  = (Addr == DATA_ADDR);
    assign is_stat  = (Addr == STAT_ADDR);
    assign Hit      = (is_data | is_stat) & (MemRead | MemWrite);
    assign Ram1_Off = Hit;
    assign data_hit = Hit & is_data;
    // A flushed access still finishes its strobe phase but never reports DONE.
    assign live     = data_hit & ~abort_q;

    assign Stall = Rst & data_hit & (state_q != DONE) &
                   ((state_q != IDLE) | MemWrite | (MemRead & dr_s));

    always_comb begin
        DataOut = 16'h0000;
        if (Hit && MemRead) begin
            if (is_stat)
                DataOut = {14'b0, dr_s, tbre_s & tsre_s & (state_q == IDLE)};
            else if (state_q == DONE)
                DataOut = {8'h00, rx_q};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        abort_d = abort_q | ((state_q != IDLE) & ~data_hit);
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (data_hit && MemWrite) begin
                    tx_d    = DataIn[7:0];
                    state_d = WR_SETUP;
                end else if (data_hit && MemRead && dr_s) begin
                    cnt_d   = CW'(RD_PULSE - 1);
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rx_d    = Uart_data;
                    state_d = live ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_SETUP: begin
                cnt_d   = CW'(WR_PULSE - 1);
                state_d = WR;
            end
            WR: begin
                if (cnt_q == '0) state_d = WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WR_HOLD: state_d = live ? WR_WAIT : IDLE;
            WR_WAIT: begin
                if (!live)                state_d = IDLE;
                else if (tbre_s && tsre_s) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and bus enable are registered from the next state so they never glitch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            abort_q     <= 1'b0;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            drive_q     <= 1'b0;
            dr_sync_q   <= 2'b00;
            tbre_sync_q <= 2'b00;
            tsre_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            abort_q     <= abort_d;
            rdn_q       <= (state_d != RD);
            wrn_q       <= (state_d != WR);
            drive_q     <= (state_d == WR_SETUP) | (state_d == WR) | (state_d == WR_HOLD);
            dr_sync_q   <= {dr_sync_q[0], data_ready};
            tbre_sync_q <= {tbre_sync_q[0], tbre};
            tsre_sync_q <= {tsre_sync_q[0], tsre};
        end
    end

    assign rdn         = rdn_q;
    assign wrn         = wrn_q;
    assign Uart_data   = drive_q ? tx_q : 8'hzz;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: directed scenarios plus a randomized mix, checked against a
// transaction-level model of the UART access protocol and a queue of bytes expected on the wire.
module tb_uart_mmio;
    localparam logic [15:0] DATA_ADDR = 16'hBF00;
    localparam logic [15:0] STAT_ADDR = 16'hBF01;
    localparam int RD_PULSE = 2;
    localparam int WR_PULSE = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Addr, DataIn;
    logic        MemRead, MemWrite;
    logic        data_ready, tbre, tsre;
    wire  [15:0] DataOut;
    wire         Hit, Ram1_Off, Stall, rdn, wrn;
    wire  [7:0]  Uart_data;
    wire  [2:0]  dbg_state_o;
    logic [7:0]  uart_drv;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];

    uart_mmio #(.DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE)) dut (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .DataIn(DataIn), .MemRead(MemRead), .MemWrite(MemWrite),
        .DataOut(DataOut), .Hit(Hit), .Ram1_Off(Ram1_Off), .Stall(Stall), .rdn(rdn), .wrn(wrn),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .Uart_data(Uart_data), .dbg_state_o(dbg_state_o)
    );

    // Released bus floats high so "not driven" is observable.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (Uart_data[g]);
    end
    assign Uart_data = !rdn ? uart_drv : 8'hzz;

    always #5 Clk = ~Clk;

    // UART chip side: latches the bus on the rising edge of wrn.
    always @(posedge wrn) if (Rst === 1'b1) tx_log.push_back(Uart_data);

    task automatic idle_bus();
        Addr = 16'h0000; DataIn = 16'h0000; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic set_lines(input logic dr, input logic tb, input logic ts);
        data_ready = dr; tbre = tb; tsre = ts;
        repeat (3) @(negedge Clk);
    endtask

    // Issue a load and hold it until Stall drops; Stall count includes the decode cycle.
    task automatic do_read(input logic [15:0] addr, output logic [15:0] dout,
                           output int stall_n, output int rdn_n);
        bit done = 0;
        @(negedge Clk);
        Addr = addr; MemRead = 1'b1; stall_n = 0; rdn_n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!rdn) rdn_n++;
            if (!Stall) begin done = 1; break; end
            stall_n++;
            @(negedge Clk);
        end
        dout = DataOut;
        checks++;
        if (!done) begin errors++; $display("FAIL read_timeout got stall_n=%0d want done", stall_n); end
        @(negedge Clk);
        idle_bus();
    endtask

    task automatic do_write(input logic [15:0] data, input bit slow,
                            output int stall_n, output int wrn_n, output int gap);
        bit done = 0;
        int first = -1;
        int ts_at = -1;
        @(negedge Clk);
        Addr = DATA_ADDR; DataIn = data; MemWrite = 1'b1; stall_n = 0; wrn_n = 0; gap = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!wrn) begin
                wrn_n++;
                checks++;
                if (Uart_data !== data[7:0]) begin
                    errors++; $display("FAIL wr_data got %h want %h", Uart_data, data[7:0]);
                end
                if (first < 0) begin
                    first = i;
                    if (slow) begin tbre = 1'b0; tsre = 1'b0; end
                end
            end
            if (!Stall) begin done = 1; if (ts_at >= 0) gap = i - ts_at; break; end
            stall_n++;
            if (slow && first >= 0 && i - first == 5) tbre = 1'b1;
            if (slow && first >= 0 && i - first == 8) begin tsre = 1'b1; ts_at = i; end
            @(negedge Clk);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL write_timeout got stall_n=%0d want done", stall_n); end
        exp_q.push_back(data[7:0]);
        @(negedge Clk);
        idle_bus();
    endtask

    task automatic test_reset();
        Rst = 1'b0; idle_bus(); set_lines(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({rdn, wrn, Stall} !== 3'b110 || DataOut !== 16'h0000 || Uart_data !== 8'hff) begin
            errors++;
            $display("FAIL reset got rdn=%b wrn=%b stall=%b dout=%h bus=%h want 1 1 0 0000 ff",
                     rdn, wrn, Stall, DataOut, Uart_data);
        end
        @(negedge Clk); Rst = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        bit seen = 0;
        set_lines(1'b0, 1'b1, 1'b1);
        @(negedge Clk);
        Addr = DATA_ADDR; DataIn = 16'h00C3; MemWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!wrn) begin seen = 1; break; end
            @(negedge Clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mid_wr_strobe got wrn=%b want 0", wrn); end
        #1 Rst = 1'b0;
        #1;
        checks++;
        if (wrn !== 1'b1 || rdn !== 1'b1 || Stall !== 1'b0 || Uart_data !== 8'hff) begin
            errors++;
            $display("FAIL rst_mid_wr got wrn=%b rdn=%b stall=%b bus=%h want 1 1 0 ff", wrn, rdn, Stall, Uart_data);
        end
        @(negedge Clk); idle_bus();
        @(negedge Clk); Rst = 1'b1;
    endtask

    task automatic test_status();
        logic [15:0] d; int s, r;
        set_lines(1'b1, 1'b1, 1'b1);
        do_read(STAT_ADDR, d, s, r);
        checks++;
        if (d !== 16'h0003 || s !== 0 || r !== 0) begin
            errors++; $display("FAIL status got dout=%h stall=%0d rdn=%0d want 0003 0 0", d, s, r);
        end
    endtask

    task automatic test_read();
        logic [15:0] d; int s, r;
        uart_drv = 8'h5A;
        set_lines(1'b1, 1'b1, 1'b1);
        do_read(DATA_ADDR, d, s, r);
        checks++;
        if (d !== 16'h005A || s !== RD_PULSE + 1 || r !== RD_PULSE) begin
            errors++; $display("FAIL read got dout=%h stall=%0d rdn=%0d want 005a %0d %0d", d, s, r, RD_PULSE + 1, RD_PULSE);
        end
    endtask

    task automatic test_write_slow();
        int s, w, g;
        set_lines(1'b0, 1'b1, 1'b1);
        do_write(16'h1241, 1'b1, s, w, g);
        checks++;
        if (w !== WR_PULSE || g !== 3) begin
            errors++; $display("FAIL write_slow got wrn_n=%0d gap=%0d want %0d 3", w, g, WR_PULSE);
        end
    endtask

    task automatic test_read_empty();
        logic [15:0] d; int s, r;
        uart_drv = 8'hA5;
        set_lines(1'b0, 1'b1, 1'b1);
        do_read(DATA_ADDR, d, s, r);
        checks++;
        if (d !== 16'h0000 || s !== 0 || r !== 0) begin
            errors++; $display("FAIL read_empty got dout=%h stall=%0d rdn=%0d want 0000 0 0", d, s, r);
        end
    endtask

    task automatic test_non_uart();
        @(negedge Clk);
        Addr = 16'h8000; MemRead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({Hit, Ram1_Off, Stall, rdn, wrn} !== 5'b00011 || Uart_data !== 8'hff) begin
                errors++;
                $display("FAIL non_uart got hit=%b off=%b stall=%b rdn=%b wrn=%b bus=%h want 0 0 0 1 1 ff",
                         Hit, Ram1_Off, Stall, rdn, wrn, Uart_data);
            end
            @(negedge Clk);
        end
        Addr = STAT_ADDR; MemRead = 1'b0; MemWrite = 1'b1; DataIn = 16'h0055;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({Hit, Ram1_Off, Stall, wrn} !== 4'b1101 || Uart_data !== 8'hff) begin
                errors++;
                $display("FAIL stat_write got hit=%b off=%b stall=%b wrn=%b bus=%h want 1 1 0 1 ff",
                         Hit, Ram1_Off, Stall, wrn, Uart_data);
            end
            @(negedge Clk);
        end
        idle_bus();
    endtask

    task automatic test_flush();
        logic [15:0] d; int s, r; bit back = 0;
        uart_drv = 8'h77;
        set_lines(1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        Addr = DATA_ADDR; MemRead = 1'b1;
        @(negedge Clk);
        #1;
        checks++;
        if (rdn !== 1'b0) begin errors++; $display("FAIL flush_strobe got rdn=%b want 0", rdn); end
        idle_bus();
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", Stall); end
        for (int i = 0; i < RD_PULSE + 2; i++) begin
            @(negedge Clk); #1;
            if (rdn) begin back = 1; break; end
        end
        checks++;
        if (!back) begin errors++; $display("FAIL flush_release got rdn=%b want 1", rdn); end
        do_read(STAT_ADDR, d, s, r);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL flush_idle got %h want 0003", d); end
    endtask

    task automatic test_random();
        logic [15:0] d, want; int s, r, w, g;
        logic dr, tb, ts;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    dr = 1'($urandom_range(0, 1)); tb = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
                    set_lines(dr, tb, ts);
                    do_read(STAT_ADDR, d, s, r);
                    want = {14'b0, dr, tb & ts};
                    checks++;
                    if (d !== want || s !== 0) begin
                        errors++; $display("FAIL rnd_status got %h/%0d want %h/0", d, s, want);
                    end
                end
                1: begin
                    dr = 1'($urandom_range(0, 1)); uart_drv = 8'($urandom);
                    set_lines(dr, 1'b1, 1'b1);
                    do_read(DATA_ADDR, d, s, r);
                    want = dr ? {8'h00, uart_drv} : 16'h0000;
                    checks++;
                    if (d !== want || s !== (dr ? RD_PULSE + 1 : 0) || r !== (dr ? RD_PULSE : 0)) begin
                        errors++; $display("FAIL rnd_read got %h/%0d/%0d want %h dr=%b", d, s, r, want, dr);
                    end
                end
                2: begin
                    set_lines(1'b0, 1'b1, 1'b1);
                    do_write(16'($urandom), 1'b0, s, w, g);
                    checks++;
                    if (s !== WR_PULSE + 4 || w !== WR_PULSE) begin
                        errors++; $display("FAIL rnd_write got stall=%0d wrn=%0d want %0d %0d", s, w, WR_PULSE + 4, WR_PULSE);
                    end
                end
                default: begin
                    @(negedge Clk);
                    Addr = 16'($urandom_range(0, 16'hBEFF)); MemRead = 1'b1;
                    #1;
                    checks++;
                    if ({Hit, Ram1_Off, Stall, rdn, wrn} !== 5'b00011) begin
                        errors++; $display("FAIL rnd_non_uart got %b want 00011 addr=%h", {Hit, Ram1_Off, Stall, rdn, wrn}, Addr);
                    end
                    idle_bus();
                end
            endcase
        end
    endtask

    task automatic test_scoreboard();
        repeat (2) @(negedge Clk);
        checks++;
        if (tx_log.size() != exp_q.size()) begin
            errors++; $display("FAIL tx_count got %0d want %0d", tx_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin
                errors++; $display("FAIL tx_byte[%0d] got %h want %h", i, tx_log[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        uart_drv = 8'h00;
        test_reset();
        test_reset_mid_write();
        test_status();
        test_read();
        test_write_slow();
        test_read_empty();
        test_non_uart();
        test_flush();
        test_random();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
